// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Exhaustive stimulus and check stage for a single 2-input combinational gate.
//   A run steps {drvA,drvB} through 00, 01, 10, 11. Each vector is held for
//   SETTLE_CYCLES settle cycles plus one sample cycle. gateY is compared against
//   EXPECTED[{A,B}] at the edge that leaves the sample cycle.
//
// Parameters
//   SETTLE_CYCLES  settle cycles per vector before sampling (>= 1)
//   EXPECTED       expected gateY per vector, bit index = {A,B} (default NAND)
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, honoured only in IDLE
//   abort      in   synchronous abort of a run in progress
//   gateY      in   output of the gate under test
//   drvA/drvB  out  registered gate inputs
//   busy       out  high in SETTLE or SAMPLE
//   done       out  one-cycle pulse when a run completes
//   pass       out  last completed run had zero mismatches
//   errCount   out  mismatch count of the current/last run (0..4)
//   failValid  out  failVec holds a captured mismatch
//   failVec    out  {A,B} of the first mismatching vector
module gate_truth_table_checker #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECTED      = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       gateY,
    output logic       drvA,
    output logic       drvB,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] errCount,
    output logic       failValid,
    output logic [1:0] failVec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       drv_q, drv_d;
    logic [2:0]       err_q, err_d;
    logic             pass_q, pass_d;
    logic             fail_valid_q, fail_valid_d;
    logic [1:0]       fail_vec_q, fail_vec_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            drv_q        <= '0;
            err_q        <= '0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            drv_q        <= drv_d;
            err_q        <= err_d;
            pass_q       <= pass_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        drv_d        = drv_q;
        err_d        = err_q;
        pass_d       = pass_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;

        unique case (state_q)
            S_IDLE: begin
                // abort outranks start, so a simultaneous request never starts a run
                if (start && !abort) begin
                    state_d      = S_SETTLE;
                    idx_d        = '0;
                    cnt_d        = '0;
                    drv_d        = '0;
                    err_d        = '0;
                    pass_d       = 1'b0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    drv_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                // an abort here discards the pending comparison
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    drv_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    if (gateY != EXPECTED[idx_q]) begin
                        if (err_q != 3'd4) begin
                            err_d = err_q + 3'd1;
                        end
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = idx_q;
                        end
                    end
                    if (idx_q != 2'd3) begin
                        state_d = S_SETTLE;
                        idx_d   = idx_q + 2'd1;
                        drv_d   = idx_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        // pass is loaded on DONE entry so it is valid alongside done
                        state_d = S_DONE;
                        drv_d   = '0;
                        pass_d  = (err_d == 3'd0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign drvA      = drv_q[1];
    assign drvB      = drv_q[0];
    assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign errCount  = err_q;
    assign failValid = fail_valid_q;
    assign failVec   = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       gate_y;
    logic       drv_a;
    logic       drv_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic       fail_valid;
    logic [1:0] fail_vec;

    // truth table of the simulated gate under test, bit index = {A,B}
    logic [3:0] gate_tbl;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [3:0] tbl;
        int         err;
        logic       fvv;
        logic [1:0] fv;
        logic       pass;
    } vec_t;

    vec_t vecs[7];

    gate_truth_table_checker #(
        .SETTLE_CYCLES(2),
        .EXPECTED     (4'b0111)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .gateY    (gate_y),
        .drvA     (drv_a),
        .drvB     (drv_b),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .errCount (err_count),
        .failValid(fail_valid),
        .failVec  (fail_vec)
    );

    assign gate_y = gate_tbl[{drv_a, drv_b}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: a NAND checker over the first n_vec vectors in order 00,01,10,11
    task automatic model(input logic [3:0] tbl, input int n_vec,
                         output int err, output logic fvv, output logic [1:0] fv);
        err = 0;
        fvv = 1'b0;
        fv  = 2'b00;
        for (int v = 0; v < n_vec; v++) begin
            logic [1:0] ab;
            logic       want;
            ab   = 2'(v);
            want = !(ab[1] && ab[0]);
            if (tbl[v] != want) begin
                err++;
                if (!fvv) begin
                    fvv = 1'b1;
                    fv  = ab;
                end
            end
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            cycle();
            lat++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_run(input logic [3:0] tbl);
        gate_tbl = tbl;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    task automatic full_run(input string name, input logic [3:0] tbl, input int e_err,
                            input logic e_fvv, input logic [1:0] e_fv, input logic e_pass);
        int lat;
        start_run(tbl);
        wait_done(lat);
        chk({name, "_latency"}, lat, 12);
        chk({name, "_err"}, err_count, e_err);
        chk({name, "_fvalid"}, fail_valid, e_fvv);
        chk({name, "_fvec"}, fail_vec, e_fv);
        cycle();
        chk({name, "_pass"}, pass, e_pass);
        chk({name, "_done_low"}, done, 0);
    endtask

    initial begin
        int         lat;
        int         e_err;
        logic       e_fvv;
        logic [1:0] e_fv;
        int         last_done;
        int         n_done;
        logic       pass_pending;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        gate_tbl = 4'b0111;

        vecs[0] = '{"nand",   4'b0111, 0, 1'b0, 2'b00, 1'b1};
        vecs[1] = '{"tied1",  4'b1111, 1, 1'b1, 2'b11, 1'b0};
        vecs[2] = '{"and",    4'b1000, 4, 1'b1, 2'b00, 1'b0};
        vecs[3] = '{"tied0",  4'b0000, 3, 1'b1, 2'b00, 1'b0};
        vecs[4] = '{"or",     4'b1110, 2, 1'b1, 2'b00, 1'b0};
        vecs[5] = '{"nota",   4'b0011, 1, 1'b1, 2'b10, 1'b0};
        vecs[6] = '{"nand2",  4'b0111, 0, 1'b0, 2'b00, 1'b1};

        // reset state
        repeat (2) cycle();
        chk("reset_outputs", {drv_a, drv_b, busy, done, pass, err_count, fail_valid, fail_vec}, 0);
        rst_n = 1'b1;
        cycle();
        chk("idle_busy", busy, 0);

        // detailed ideal-NAND run: drive sequence and done timing
        start_run(4'b0111);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_drv_%0d", i), {drv_a, drv_b}, i / 3);
            chk($sformatf("t1_busy_%0d", i), busy, 1);
            chk($sformatf("t1_done_%0d", i), done, 0);
            cycle();
        end
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_drv_end", {drv_a, drv_b}, 0);
        chk("t1_err", err_count, 0);
        chk("t1_fvalid", fail_valid, 0);
        cycle();
        chk("t1_pass", pass, 1);
        chk("t1_done_pulse", done, 0);

        // table-driven gate variants
        for (int k = 0; k < 7; k++) begin
            full_run(vecs[k].name, vecs[k].tbl, vecs[k].err, vecs[k].fvv, vecs[k].fv, vecs[k].pass);
            cycle();
        end

        // abort during DONE has no effect; start+abort in IDLE starts nothing
        start_run(4'b0111);
        wait_done(lat);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_done_pass", pass, 1);
        chk("abort_done_idle", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_pass", pass, 1);

        // second start ignored, abort lands 5 edges after start
        start_run(4'b1000);
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_drv", {drv_a, drv_b}, 0);
        chk("abort_err", err_count, 1);
        chk("abort_fvalid", fail_valid, 1);
        chk("abort_fvec", fail_vec, 0);
        chk("abort_pass", pass, 0);
        n_done = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) n_done++;
            cycle();
        end
        chk("abort_no_done", n_done, 0);
        full_run("after_abort", 4'b0111, 0, 1'b0, 2'b00, 1'b1);

        // asynchronous reset mid-run
        start_run(4'b1000);
        repeat (4) cycle();
        chk("pre_reset_err", err_count, 1);
        chk("pre_reset_drv", {drv_a, drv_b}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {drv_a, drv_b, busy, done, pass, err_count, fail_valid, fail_vec}, 0);
        repeat (4) cycle();
        chk("held_reset_outputs", {drv_a, drv_b, busy, done, pass, err_count, fail_valid, fail_vec}, 0);
        rst_n = 1'b1;
        cycle();
        full_run("after_reset", 4'b0111, 0, 1'b0, 2'b00, 1'b1);

        // start held high: back-to-back runs
        gate_tbl     = 4'b0111;
        start        = 1'b1;
        last_done    = -1;
        n_done       = 0;
        pass_pending = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (pass_pending) begin
                chk("held_pass", pass, 1);
                pass_pending = 1'b0;
            end
            if (done) begin
                if (last_done < 0) chk("held_first_done", c, 12);
                else chk("held_interval", c - last_done, 14);
                chk("held_err", err_count, 0);
                last_done    = c;
                pass_pending = 1'b1;
                n_done++;
            end
        end
        start = 1'b0;
        chk("held_done_count", n_done, 4);
        repeat (16) cycle();

        // randomized truth tables, some runs aborted at a random edge
        for (int r = 0; r < 40; r++) begin
            logic [3:0] tbl;
            int         a;
            tbl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                model(tbl, 4, e_err, e_fvv, e_fv);
                full_run($sformatf("rnd%0d", r), tbl, e_err, e_fvv, e_fv, e_err == 0);
            end else begin
                a = $urandom_range(1, 12);
                model(tbl, (a - 1) / 3, e_err, e_fvv, e_fv);
                start_run(tbl);
                repeat (a - 1) cycle();
                abort = 1'b1;
                cycle();
                abort = 1'b0;
                chk($sformatf("rab%0d_busy", r), busy, 0);
                chk($sformatf("rab%0d_done", r), done, 0);
                chk($sformatf("rab%0d_drv", r), {drv_a, drv_b}, 0);
                chk($sformatf("rab%0d_err", r), err_count, e_err);
                chk($sformatf("rab%0d_fvalid", r), fail_valid, e_fvv);
                chk($sformatf("rab%0d_fvec", r), fail_vec, e_fv);
                chk($sformatf("rab%0d_pass", r), pass, 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
